// File: rtl/partition_engine.sv
// partition_engine: in-place Lomuto partition of one sub-array range held in a
// single-port element memory. The last element of the range is the pivot; the
// pivot's final absolute position is returned on Index with a one-cycle done.
module partition_engine #(
   parameter int K = 10,
   parameter int W = 32,
   parameter int S = $clog2(K) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [S-1:0] start_index,
   input  logic [S-1:0] element_count,
   output logic         busy,
   output logic         done,
   output logic [S-1:0] Index,
   output logic [S-1:0] mem_addr,
   output logic         mem_rd_en,
   input  logic [W-1:0] mem_rdata,
   output logic         mem_we,
   output logic [W-1:0] mem_wdata
);

   typedef enum logic [3:0] {
      IDLE, RD_PIV, CAP_PIV, RD_J, CMP, RD_I, WR_J, WR_I,
      FIN, WR_HI, WR_PIV, DONE_ST
   } state_t;

   state_t         state_reg;
   logic [S-1:0]   hi_reg;
   logic [S-1:0]   i_reg;
   logic [S-1:0]   j_reg;
   logic [W-1:0]   pivot_reg;
   logic [W-1:0]   aj_reg;
   logic [W-1:0]   wdata_reg;
   // When set, the write data is the word the memory is returning this cycle
   // (the element read one cycle earlier), so it is forwarded from mem_rdata.
   logic           wsel_reg;

   logic [S-1:0]   hi_start;
   logic [S-1:0]   i_inc;
   logic [S-1:0]   j_inc;
   logic [S-1:0]   i_adv;
   logic           lt;
   logic           adv_fin;

   // Helper arithmetic for range setup, the compare and the j-advance step.
   always_comb begin
      hi_start = start_index + element_count - S'(1);
      i_inc    = i_reg + S'(1);
      j_inc    = j_reg + S'(1);
      lt       = (mem_rdata < pivot_reg);
      // i moves after a completed swap, or in CMP when A[j] < pivot with i == j
      i_adv    = ((state_reg == WR_I) || lt) ? i_inc : i_reg;
      adv_fin  = (j_inc == hi_reg);
   end

   assign mem_wdata = wsel_reg ? mem_rdata : wdata_reg;

   // Partition sequencer; every strobe is registered on entry to its state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         Index     <= '0;
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         mem_we    <= 1'b0;
         wdata_reg <= '0;
         wsel_reg  <= 1'b0;
         hi_reg    <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
         pivot_reg <= '0;
         aj_reg    <= '0;
      end else begin
         mem_rd_en <= 1'b0;
         mem_we    <= 1'b0;
         done      <= 1'b0;
         wsel_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (element_count >= S'(2)) begin
                     hi_reg    <= hi_start;
                     i_reg     <= start_index;
                     j_reg     <= start_index;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= hi_start;
                     state_reg <= RD_PIV;
                  end else begin
                     done      <= 1'b1;
                     Index     <= start_index;
                     state_reg <= DONE_ST;
                  end
               end
            end
            RD_PIV: state_reg <= CAP_PIV;
            CAP_PIV: begin
               pivot_reg <= mem_rdata;
               mem_rd_en <= 1'b1;
               mem_addr  <= j_reg;
               state_reg <= RD_J;
            end
            RD_J: state_reg <= CMP;
            CMP: begin
               aj_reg <= mem_rdata;
               if (lt && (i_reg != j_reg)) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= i_reg;
                  state_reg <= RD_I;
               end else begin
                  i_reg <= i_adv;
                  j_reg <= j_inc;
                  if (adv_fin) begin
                     mem_rd_en <= (i_adv != hi_reg);
                     mem_addr  <= i_adv;
                     state_reg <= FIN;
                  end else begin
                     mem_rd_en <= 1'b1;
                     mem_addr  <= j_inc;
                     state_reg <= RD_J;
                  end
               end
            end
            RD_I: begin
               mem_we    <= 1'b1;
               mem_addr  <= j_reg;
               wsel_reg  <= 1'b1;
               state_reg <= WR_J;
            end
            WR_J: begin
               mem_we    <= 1'b1;
               mem_addr  <= i_reg;
               wdata_reg <= aj_reg;
               state_reg <= WR_I;
            end
            WR_I: begin
               i_reg <= i_adv;
               j_reg <= j_inc;
               if (adv_fin) begin
                  mem_rd_en <= (i_adv != hi_reg);
                  mem_addr  <= i_adv;
                  state_reg <= FIN;
               end else begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= j_inc;
                  state_reg <= RD_J;
               end
            end
            FIN: begin
               if (i_reg == hi_reg) begin
                  done      <= 1'b1;
                  Index     <= i_reg;
                  state_reg <= DONE_ST;
               end else begin
                  mem_we    <= 1'b1;
                  mem_addr  <= hi_reg;
                  wsel_reg  <= 1'b1;
                  state_reg <= WR_HI;
               end
            end
            WR_HI: begin
               mem_we    <= 1'b1;
               mem_addr  <= i_reg;
               wdata_reg <= pivot_reg;
               state_reg <= WR_PIV;
            end
            WR_PIV: begin
               done      <= 1'b1;
               Index     <= i_reg;
               state_reg <= DONE_ST;
            end
            DONE_ST: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/partition_engine.md
# partition_engine

Quicksort partition executor: the responder to the range-stack controller. It accepts a sub-array range (start_index, element_count) and runs a Lomuto partition in place over a single-port element memory, using the last element of the range as pivot. It returns the pivot's final absolute position on Index, which the controller uses to push the left and right sub-ranges.

## Interface
- K, 10, number of elements in the array
- W, 32, element width (unsigned compare)
- S, $clog2(K)+1, index/count width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- start_index  in  S  first element of range; sampled with start
- element_count  in  S  range length; sampled with start
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse; Index is valid
- Index  out  S  final pivot position, absolute address; held until the next start is accepted
- mem_addr  out  S  memory address
- mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  W  read data
- mem_we  out  1  write strobe; write commits at the clock edge
- mem_wdata  out  W  write data

## Operation
- Registers: lo, hi = lo+count-1 (S bits, mod 2^S), i, j, pivot, aj, ai. All outputs are registered.
- Algorithm: i=lo; for each j in lo..hi-1, if A[j] < pivot (strict, unsigned), swap A[i] and A[j], then i++. Finally swap A[i] and A[hi]. Index=i.
- States:
  - IDLE: on start with count>=2, latch lo/hi, set i=j=lo → RD_PIV. On start with count<=1 → DONE with Index=start_index and no memory access.
  - RD_PIV: rd_en, addr=hi → CAP_PIV.
  - CAP_PIV: pivot←rdata → RD_J.
  - RD_J: rd_en, addr=j → CMP.
  - CMP: aj←rdata.
    - If rdata<pivot and i≠j → RD_I.
    - If rdata<pivot and i==j: i++, then advance.
    - Otherwise: advance.
  - RD_I: rd_en, addr=i → WR_J.
  - WR_J: we, addr=j, wdata=rdata (old A[i]) → WR_I.
  - WR_I: we, addr=i, wdata=aj; i++; advance.
  - advance: j++. If the new j==hi → FIN, else → RD_J.
  - FIN: if i==hi → DONE (no writes). Else rd_en, addr=i → WR_HI.
  - WR_HI: we, addr=hi, wdata=rdata → WR_PIV.
  - WR_PIV: we, addr=i, wdata=pivot → DONE.
  - DONE: done=1, Index=i → IDLE.
- mem_rd_en and mem_we are never high in the same cycle. mem_addr and mem_wdata are don't-care when both strobes are low.
- start while busy: ignored.
- No range checking: lo+count-1 beyond K-1 is a caller error, and addresses wrap mod 2^S.

## Timing
- Reset values: busy=0, done=0, Index=0, mem_rd_en=0, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE.
- Reset mid-operation: takes effect at the next edge. The FSM returns to IDLE with all outputs at reset values. Memory contents are left partially permuted; no write is issued in the reset cycle.
- Start sampled at edge 0. done is high in cycle C, where C = 2n+2+3s+2f:
  - n = element_count
  - s = swaps with i≠j
  - f = 1 if the final swap is performed
- count<=1: done in cycle 1.
- Index changes only at the DONE transition.

## Test plan
- Basic partition: A[0..4]=[5,3,8,1,4], start_index=0, count=5 → A=[3,1,4,5,8], Index=2, done in cycle 20.
- Sorted input: A[0..3]=[1,2,3,4], start 0, count 4 → Index=3, mem_we never asserted, done in cycle 10, memory unchanged.
- Reverse input: A[0..3]=[9,7,5,2], start 0, count 4 → A=[2,7,5,9], Index=0, done in cycle 12.
- Subrange with duplicates: A[3..5]=[6,6,6], start 3, count 3 → Index=3, exactly two writes (addr 5, then addr 3, both data 6), A[0..2] and A[6..9] untouched.
- Trivial range: start 7, count 1 → done in cycle 1, Index=7, no rd_en/we; start pulsed while busy during another run is ignored.
- Reset mid-run: pull rst_n low while in CMP → next cycle busy=0, done=0, mem_we=0, Index=0. A fresh start on [5,3,8,1,4] then completes as in the first scenario.
